rtc_responder: RTL

Cycle-accurate real-time-clock responder answering the register bus driven by the top-level state machine: address `dir`, write data `dato`, direction `RD_WR`, strobe `cs`, read data back on `dato_rtc`. Keeps BCD time/date and a BCD countdown timer ticking from a divided clock. Drives `crono_end` when the timer expires. Sits on the RTC side of the bus, in place of the external RTC chip, for FPGA-only builds and for system simulation.

---
 rtl/rtc_pkg.sv | 46 ++++
 rtl/bcd_pair_counter.sv | 55 +++++
 rtl/rtc_responder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the RTC responder.
//   - register map addresses (BCD time/date and countdown timer)
//   - timer state encoding
//   - per-field min/max limits
//   - month_days(): last valid day of a BCD month, leap-aware
package rtc_pkg;

   localparam logic [7:0] ADDR_SEC   = 8'h21;
   localparam logic [7:0] ADDR_MIN   = 8'h22;
   localparam logic [7:0] ADDR_HOUR  = 8'h23;
   localparam logic [7:0] ADDR_DAY   = 8'h24;
   localparam logic [7:0] ADDR_MON   = 8'h25;
   localparam logic [7:0] ADDR_YEAR  = 8'h26;
   localparam logic [7:0] ADDR_TSEC  = 8'h41;
   localparam logic [7:0] ADDR_TMIN  = 8'h42;
   localparam logic [7:0] ADDR_THOUR = 8'h43;

   localparam logic [7:0] FIELD_MIN = 8'h00;
   localparam logic [7:0] DAY_MIN   = 8'h01;
   localparam logic [7:0] MON_MIN   = 8'h01;
   localparam logic [7:0] SEC_MAX   = 8'h59;
   localparam logic [7:0] MIN_MAX   = 8'h59;
   localparam logic [7:0] HOUR_MAX  = 8'h23;
   localparam logic [7:0] MON_MAX   = 8'h12;
   localparam logic [7:0] YEAR_MAX  = 8'h99;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE
   } crono_state_t;

   // Year is BCD, so its value mod 4 is (2*tens + units) mod 4; year 00 is leap.
   // Unrecognised month codes fall back to 31 days.
   function automatic logic [7:0] month_days(input logic [7:0] month,
                                             input logic [7:0] year);
      int unsigned year_val;
      year_val = 32'(year[7:4]) * 2 + 32'(year[3:0]);
      case (month)
         8'h04, 8'h06, 8'h09, 8'h11: month_days = 8'h30;
         8'h02:   month_days = ((year_val % 4) == 0) ? 8'h29 : 8'h28;
         default: month_days = 8'h31;
      endcase
   endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// bcd_pair_counter: two-digit BCD register that can be loaded, incremented
// or decremented, wrapping between min_val and max_val.
//   clk, reset     : clock, asynchronous active-low reset (q -> RST_VAL)
//   inc / dec      : count up / down this cycle (inc has priority)
//   load, load_val : overwrite q this cycle (priority over counting)
//   min_val/max_val: wrap limits, compared as raw 8-bit values
//   q, q_nxt       : current value and the value taken at the next edge
//   wrap           : carry (inc at/above max) or borrow (dec at/below min)
module bcd_pair_counter #(
   parameter logic [7:0] RST_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       dec,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic [7:0] min_val,
   input  logic [7:0] max_val,
   output logic [7:0] q,
   output logic [7:0] q_nxt,
   output logic       wrap
);

   logic       at_max;
   logic       at_min;
   logic [7:0] q_inc;
   logic [7:0] q_dec;

   always_comb begin
      at_max = (q >= max_val);
      at_min = (q <= min_val);
      if (q[3:0] >= 4'd9) q_inc = {q[7:4] + 4'd1, 4'd0};
      else                q_inc = {q[7:4], q[3:0] + 4'd1};
      if (q[3:0] == 4'd0) q_dec = {q[7:4] - 4'd1, 4'd9};
      else                q_dec = {q[7:4], q[3:0] - 4'd1};
   end

   // wrap depends on the old value only, so a load in the same cycle still
   // lets the neighbouring field see the carry/borrow it would have produced.
   assign wrap = (inc & at_max) | (dec & at_min);

   always_comb begin
      q_nxt = q;
      if (load)     q_nxt = load_val;
      else if (inc) q_nxt = at_max ? min_val : q_inc;
      else if (dec) q_nxt = at_min ? max_val : q_dec;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q <= RST_VAL;
      else        q <= q_nxt;
   end

endmodule

// File: rtl/rtc_responder.sv
// rtc_responder: stand-in for the external RTC chip on the register bus.
// Keeps BCD time/date and a BCD countdown timer driven by a one-second tick.
//   clk, reset          : clock, asynchronous active-low reset
//   cs, RD_WR, dir, dato: one-cycle strobe, 1=read/0=write, address, write data
//   dato_rtc, ack       : registered read data and acknowledge (two edges after cs)
//   ini_crono/stop_crono: start-resume / pause pulses for the timer
//   crono_end           : one-cycle pulse when the timer reaches 00:00:00
module rtc_responder
   import rtc_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs,
   input  logic       RD_WR,
   input  logic [7:0] dir,
   input  logic [7:0] dato,
   output logic [7:0] dato_rtc,
   output logic       ack,
   input  logic       ini_crono,
   input  logic       stop_crono,
   output logic       crono_end
);

   localparam int unsigned DIV_W = $clog2(TICK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             tick;

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + DIV_W'(1);
   end

   logic wr;
   assign wr = cs & ~RD_WR;

   // Clock/date chain
   logic [7:0] sec_q, min_q, hour_q, day_q, mon_q, year_q;
   logic       sec_w, min_w, hour_w, day_w, mon_w, year_w_unused;
   logic [7:0] sec_nxt_unused, min_nxt_unused, hour_nxt_unused;
   logic [7:0] day_nxt_unused, mon_nxt_unused, year_nxt_unused;

   bcd_pair_counter #(.RST_VAL(FIELD_MIN)) u_sec (
      .clk(clk), .reset(reset), .inc(tick), .dec(1'b0),
      .load(wr && dir == ADDR_SEC), .load_val(dato),
      .min_val(FIELD_MIN), .max_val(SEC_MAX),
      .q(sec_q), .q_nxt(sec_nxt_unused), .wrap(sec_w)
   );

   bcd_pair_counter #(.RST_VAL(FIELD_MIN)) u_min (
      .clk(clk), .reset(reset), .inc(sec_w), .dec(1'b0),
      .load(wr && dir == ADDR_MIN), .load_val(dato),
      .min_val(FIELD_MIN), .max_val(MIN_MAX),
      .q(min_q), .q_nxt(min_nxt_unused), .wrap(min_w)
   );

   bcd_pair_counter #(.RST_VAL(FIELD_MIN)) u_hour (
      .clk(clk), .reset(reset), .inc(min_w), .dec(1'b0),
      .load(wr && dir == ADDR_HOUR), .load_val(dato),
      .min_val(FIELD_MIN), .max_val(HOUR_MAX),
      .q(hour_q), .q_nxt(hour_nxt_unused), .wrap(hour_w)
   );

   bcd_pair_counter #(.RST_VAL(DAY_MIN)) u_day (
      .clk(clk), .reset(reset), .inc(hour_w), .dec(1'b0),
      .load(wr && dir == ADDR_DAY), .load_val(dato),
      .min_val(DAY_MIN), .max_val(month_days(mon_q, year_q)),
      .q(day_q), .q_nxt(day_nxt_unused), .wrap(day_w)
   );

   bcd_pair_counter #(.RST_VAL(MON_MIN)) u_mon (
      .clk(clk), .reset(reset), .inc(day_w), .dec(1'b0),
      .load(wr && dir == ADDR_MON), .load_val(dato),
      .min_val(MON_MIN), .max_val(MON_MAX),
      .q(mon_q), .q_nxt(mon_nxt_unused), .wrap(mon_w)
   );

   bcd_pair_counter #(.RST_VAL(FIELD_MIN)) u_year (
      .clk(clk), .reset(reset), .inc(mon_w), .dec(1'b0),
      .load(wr && dir == ADDR_YEAR), .load_val(dato),
      .min_val(FIELD_MIN), .max_val(YEAR_MAX),
      .q(year_q), .q_nxt(year_nxt_unused), .wrap(year_w_unused)
   );

   // Countdown timer
   crono_state_t state, state_n;
   logic         crono_end_n;
   logic         t_dec;
   logic [7:0]   tsec_q, tmin_q, thour_q;
   logic [7:0]   tsec_n, tmin_n, thour_n;
   logic         tsec_w, tmin_w, thour_w_unused;
   logic         t_zero, t_nxt_zero;

   assign t_zero     = ({tsec_q, tmin_q, thour_q} == '0);
   assign t_nxt_zero = ({tsec_n, tmin_n, thour_n} == '0);
   // A zero value never decrements, so the hour field never borrows.
   assign t_dec      = (state == RUN) & tick & ~stop_crono & ~t_zero;

   bcd_pair_counter #(.RST_VAL(FIELD_MIN)) u_tsec (
      .clk(clk), .reset(reset), .inc(1'b0), .dec(t_dec),
      .load(wr && dir == ADDR_TSEC), .load_val(dato),
      .min_val(FIELD_MIN), .max_val(SEC_MAX),
      .q(tsec_q), .q_nxt(tsec_n), .wrap(tsec_w)
   );

   bcd_pair_counter #(.RST_VAL(FIELD_MIN)) u_tmin (
      .clk(clk), .reset(reset), .inc(1'b0), .dec(tsec_w),
      .load(wr && dir == ADDR_TMIN), .load_val(dato),
      .min_val(FIELD_MIN), .max_val(MIN_MAX),
      .q(tmin_q), .q_nxt(tmin_n), .wrap(tmin_w)
   );

   bcd_pair_counter #(.RST_VAL(FIELD_MIN)) u_thour (
      .clk(clk), .reset(reset), .inc(1'b0), .dec(tmin_w),
      .load(wr && dir == ADDR_THOUR), .load_val(dato),
      .min_val(FIELD_MIN), .max_val(HOUR_MAX),
      .q(thour_q), .q_nxt(thour_n), .wrap(thour_w_unused)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         crono_end <= 1'b0;
      end else begin
         state     <= state_n;
         crono_end <= crono_end_n;
      end
   end

   // Expiry is judged on the value the timer takes at this edge, so the
   // pulse lands in the cycle right after the tick that reaches zero.
   always_comb begin
      state_n     = state;
      crono_end_n = 1'b0;
      case (state)
         IDLE, PAUSE: begin
            if (!stop_crono && ini_crono) begin
               if (t_nxt_zero) begin
                  state_n     = IDLE;
                  crono_end_n = 1'b1;
               end else begin
                  state_n = RUN;
               end
            end
         end
         RUN: begin
            if (stop_crono) begin
               state_n = PAUSE;
            end else if (t_nxt_zero) begin
               state_n     = IDLE;
               crono_end_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Bus response: capture at the strobe edge, answer one edge later.
   logic       ack_pend;
   logic       rd_pend;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;

   always_comb begin
      rd_data = '0;
      case (rd_addr)
         ADDR_SEC:   rd_data = sec_q;
         ADDR_MIN:   rd_data = min_q;
         ADDR_HOUR:  rd_data = hour_q;
         ADDR_DAY:   rd_data = day_q;
         ADDR_MON:   rd_data = mon_q;
         ADDR_YEAR:  rd_data = year_q;
         ADDR_TSEC:  rd_data = tsec_q;
         ADDR_TMIN:  rd_data = tmin_q;
         ADDR_THOUR: rd_data = thour_q;
         default:    rd_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_pend <= 1'b0;
         rd_pend  <= 1'b0;
         rd_addr  <= '0;
         ack      <= 1'b0;
         dato_rtc <= '0;
      end else begin
         ack_pend <= cs;
         rd_pend  <= cs & RD_WR;
         rd_addr  <= dir;
         ack      <= ack_pend;
         if (rd_pend) dato_rtc <= rd_data;
      end
   end

endmodule
